// File: rtl/mips_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : mips_register_file_mp
// Description : Multi-port MIPS register file. N combinational read ports,
//               byte-lane writes, same-cycle write-to-read bypass, a
//               per-register pending-load scoreboard and a sequential
//               soft-clear engine. A dedicated $v0 tap exposes register 2.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_register_file_mp #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int NUM_READ_PORTS = 2,
  parameter int BYPASS         = 1,
  parameter int ZERO_REG       = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 write_enable,
  input  logic [ADDR_WIDTH-1:0]                write_reg,
  input  logic [DATA_WIDTH-1:0]                write_data,
  input  logic [DATA_WIDTH/8-1:0]              write_byte_en,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] read_reg,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] read_data,
  output logic [NUM_READ_PORTS-1:0]            read_busy,
  output logic [DATA_WIDTH-1:0]                read_data_v0,
  input  logic                                 pend_set,
  input  logic [ADDR_WIDTH-1:0]                pend_reg,
  input  logic                                 clear_start,
  output logic                                 clear_busy
);

  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int NUM_LANES = DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]   regs [DEPTH];
  logic [DEPTH-1:0]        busy;

  logic                    write_ok;
  logic                    pend_ok;
  logic [DATA_WIDTH-1:0]   lane_mask;
  logic [DATA_WIDTH-1:0]   merged;

  // Gating on reset keeps the bypass path from forwarding data while reset is held
  assign write_ok = reset && write_enable && (state == ST_IDLE) &&
                    !((ZERO_REG != 0) && (write_reg == '0));
  assign pend_ok  = pend_set && (state == ST_IDLE) &&
                    !((ZERO_REG != 0) && (pend_reg == '0));

  // Expand byte enables to a bit mask and merge new lanes over stored data
  always_comb begin
    lane_mask = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      lane_mask[8*k +: 8] = {8{write_byte_en[k]}};
    end
    merged = (write_data & lane_mask) | (regs[write_reg] & ~lane_mask);
  end

  // Register storage: soft clear has priority, writes only land in IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (state == ST_CLEAR) begin
      regs[clr_cnt] <= '0;
    end else if (write_ok) begin
      regs[write_reg] <= merged;
    end
  end

  // Pending-load scoreboard: a new load on the same edge as its writeback wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else if (state == ST_CLEAR) begin
      busy[clr_cnt] <= 1'b0;
    end else begin
      if (write_ok) busy[write_reg] <= 1'b0;
      if (pend_ok)  busy[pend_reg]  <= 1'b1;
    end
  end

  // Soft-clear sequencer: walks every index once, DEPTH cycles in total
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      clr_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          clr_cnt <= '0;
          if (clear_start) state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          if (clr_cnt == {ADDR_WIDTH{1'b1}}) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          clr_cnt <= '0;
        end
      endcase
    end
  end

  assign clear_busy   = (state == ST_CLEAR);
  assign read_data_v0 = regs[2];

  generate
    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_read
      logic [ADDR_WIDTH-1:0] idx;
      logic                  is_zero;
      logic                  hit;
      assign idx     = read_reg[p*ADDR_WIDTH +: ADDR_WIDTH];
      assign is_zero = (ZERO_REG != 0) && (idx == '0);
      assign hit     = (BYPASS != 0) && write_ok && (idx == write_reg);
      // Zero register dominates, then same-cycle forwarding, then storage
      always_comb begin
        if (is_zero) begin
          read_data[p*DATA_WIDTH +: DATA_WIDTH] = '0;
          read_busy[p]                          = 1'b0;
        end else if (hit) begin
          read_data[p*DATA_WIDTH +: DATA_WIDTH] = merged;
          read_busy[p]                          = 1'b0;
        end else begin
          read_data[p*DATA_WIDTH +: DATA_WIDTH] = regs[idx];
          read_busy[p]                          = busy[idx];
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mips_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_register_file_mp
// Description : Directed bench for mips_register_file_mp; expected values are
//               queued when stimulus is driven and popped at each check.
//               A second instance runs with forwarding disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_register_file_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_enable;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [3:0]  write_byte_en;
  logic [9:0]  read_reg;
  logic        pend_set;
  logic [4:0]  pend_reg;
  logic        clear_start;

  logic [63:0] rdata,  rdata_nb;
  logic [1:0]  rbusy,  rbusy_nb;
  logic [31:0] v0,     v0_nb;
  logic        cbusy,  cbusy_nb;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mips_register_file_mp dut (
    .clk(clk), .reset(reset), .write_enable(write_enable), .write_reg(write_reg),
    .write_data(write_data), .write_byte_en(write_byte_en), .read_reg(read_reg),
    .read_data(rdata), .read_busy(rbusy), .read_data_v0(v0),
    .pend_set(pend_set), .pend_reg(pend_reg), .clear_start(clear_start),
    .clear_busy(cbusy)
  );

  mips_register_file_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .write_enable(write_enable), .write_reg(write_reg),
    .write_data(write_data), .write_byte_en(write_byte_en), .read_reg(read_reg),
    .read_data(rdata_nb), .read_busy(rbusy_nb), .read_data_v0(v0_nb),
    .pend_set(pend_set), .pend_reg(pend_reg), .clear_start(clear_start),
    .clear_busy(cbusy_nb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    read_reg = {a1, a0};
  endtask

  task automatic drive_wr(input logic [4:0] r, input logic [31:0] d, input logic [3:0] m);
    write_enable  = 1'b1;
    write_reg     = r;
    write_data    = d;
    write_byte_en = m;
  endtask

  task automatic idle_inputs();
    write_enable = 1'b0;
    pend_set     = 1'b0;
    clear_start  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ncyc;
    reset = 1'b0;
    idle_inputs();
    write_reg = '0; write_data = '0; write_byte_en = '0;
    pend_reg = '0; read_reg = '0;

    // ---- reset held: outputs at zero
    tick(); set_rd(5'd16, 5'd2); settle();
    push(32'h0); push(32'h0); push(32'h0); push(32'h0);
    check("rst_rdata0", rdata[31:0]);
    check("rst_v0", v0);
    check("rst_busy", {30'd0, rbusy});
    check("rst_clear_busy", {31'd0, cbusy});

    reset = 1'b1;
    tick();

    // ---- all registers zero, not busy
    for (int r = 0; r < 32; r += 2) begin
      set_rd(r[4:0], 5'(r + 1)); settle();
      push(32'h0); push(32'h0); push(32'h0);
      check("init_rd0", rdata[31:0]);
      check("init_rd1", rdata[63:32]);
      check("init_busy", {30'd0, rbusy});
      tick();
    end
    push(32'h0); check("init_clear_busy", {31'd0, cbusy});

    // ---- full write then byte-lane write
    drive_wr(5'd16, 32'h0012D687, 4'hF); tick(); idle_inputs();
    set_rd(5'd16, 5'd0); settle();
    push(32'h0012D687); check("wr16_full", rdata[31:0]);
    drive_wr(5'd16, 32'hAABBCCDD, 4'b0101); settle();
    push(32'h00BBD6DD); check("wr16_lane_bypass", rdata[31:0]);
    tick(); idle_inputs(); settle();
    push(32'h00BBD6DD); check("wr16_lane", rdata[31:0]);

    // ---- bypass vs no bypass
    set_rd(5'd0, 5'd20);
    drive_wr(5'd20, 32'd7654321, 4'hF); settle();
    push(32'd7654321); push(32'd0);
    check("bypass_same_cycle", rdata[63:32]);
    check("nobypass_same_cycle", rdata_nb[63:32]);
    tick(); idle_inputs(); settle();
    push(32'd7654321); push(32'd7654321);
    check("bypass_after", rdata[63:32]);
    check("nobypass_after", rdata_nb[63:32]);

    // ---- scoreboard
    pend_set = 1'b1; pend_reg = 5'd8; tick(); idle_inputs();
    set_rd(5'd8, 5'd0); settle();
    push(32'd1); check("pend8_busy", {31'd0, rbusy[0]});
    drive_wr(5'd8, 32'd5, 4'hF); settle();
    push(32'd0); push(32'd5); push(32'd1);
    check("pend8_bypass_busy", {31'd0, rbusy[0]});
    check("pend8_bypass_data", rdata[31:0]);
    check("pend8_nobypass_busy", {31'd0, rbusy_nb[0]});
    tick(); idle_inputs(); settle();
    push(32'd0); push(32'd5);
    check("pend8_after_busy", {31'd0, rbusy[0]});
    check("pend8_after_data", rdata[31:0]);

    drive_wr(5'd9, 32'h00001234, 4'hF); pend_set = 1'b1; pend_reg = 5'd9;
    set_rd(5'd9, 5'd8);
    tick(); idle_inputs(); settle();
    push(32'd1); push(32'h00001234);
    check("same_edge_busy", {31'd0, rbusy[0]});
    check("same_edge_data", rdata[31:0]);
    pend_set = 1'b1; pend_reg = 5'd9; tick(); idle_inputs(); settle();
    push(32'd1); check("repend_busy", {31'd0, rbusy[0]});
    drive_wr(5'd9, 32'hFFFFFFFF, 4'h0); tick(); idle_inputs(); settle();
    push(32'd0); push(32'h00001234);
    check("mask0_busy", {31'd0, rbusy[0]});
    check("mask0_data", rdata[31:0]);

    // ---- zero register and v0 tap
    set_rd(5'd0, 5'd0);
    drive_wr(5'd0, 32'hFFFFFFFF, 4'hF); pend_set = 1'b1; pend_reg = 5'd0; settle();
    push(32'd0); push(32'd0);
    check("zero_same_cycle", rdata[31:0]);
    check("zero_busy_same", {31'd0, rbusy[0]});
    tick(); idle_inputs(); settle();
    push(32'd0); push(32'd0);
    check("zero_after", rdata[31:0]);
    check("zero_busy_after", {31'd0, rbusy[0]});
    drive_wr(5'd2, 32'd99, 4'hF); settle();
    push(32'd0); check("v0_not_bypassed", v0);
    tick(); idle_inputs(); settle();
    push(32'd99); check("v0_after", v0);

    // ---- fill and soft clear
    for (int r = 1; r < 32; r++) begin
      drive_wr(r[4:0], 32'h01010101 * r, 4'hF); tick();
    end
    idle_inputs();
    pend_set = 1'b1; pend_reg = 5'd5; tick(); idle_inputs();
    set_rd(5'd31, 5'd5); settle();
    push(32'h1F1F1F1F); push(32'd1);
    check("fill31", rdata[31:0]);
    check("fill5_busy", {31'd0, rbusy[1]});

    set_rd(5'd3, 5'd31);
    clear_start = 1'b1; drive_wr(5'd3, 32'h0000CAFE, 4'hF); settle();
    push(32'd0); check("clear_busy_before", {31'd0, cbusy});
    tick(); idle_inputs(); settle();
    push(32'h0000CAFE); check("write_with_clear_start", rdata[31:0]);
    push(32'd32);
    ncyc = 0;
    for (int c = 0; c < 40; c++) begin
      if (!cbusy) break;
      ncyc++;
      if (ncyc == 2) begin
        drive_wr(5'd31, 32'h0000DEAD, 4'hF); pend_set = 1'b1; pend_reg = 5'd31;
      end else begin
        idle_inputs();
      end
      tick(); settle();
    end
    idle_inputs();
    check("clear_cycles", ncyc);
    for (int r = 0; r < 32; r += 2) begin
      set_rd(r[4:0], 5'(r + 1)); settle();
      push(32'h0); push(32'h0); push(32'h0);
      check("cleared_rd0", rdata[31:0]);
      check("cleared_rd1", rdata[63:32]);
      check("cleared_busy", {30'd0, rbusy});
      tick();
    end
    push(32'd0); check("cleared_v0", v0);

    // ---- reset mid-clear
    for (int r = 1; r < 32; r++) begin
      drive_wr(r[4:0], 32'hA5000000 | r, 4'hF); tick();
    end
    idle_inputs();
    pend_set = 1'b1; pend_reg = 5'd30; tick(); idle_inputs();
    clear_start = 1'b1; tick(); idle_inputs();
    for (int c = 1; c < 10; c++) tick();
    set_rd(5'd30, 5'd20); settle();
    push(32'hA500001E); push(32'd1);
    check("midclear_data", rdata[31:0]);
    check("midclear_clear_busy", {31'd0, cbusy});
    reset = 1'b0; #1;
    push(32'd0); push(32'd0); push(32'd0); push(32'd0); push(32'd0);
    check("abort_data30", rdata[31:0]);
    check("abort_data20", rdata[63:32]);
    check("abort_busy", {30'd0, rbusy});
    check("abort_clear_busy", {31'd0, cbusy});
    check("abort_v0", v0);
    tick(); reset = 1'b1; tick(); settle();
    push(32'd0); push(32'd0);
    check("post_reset_clear_busy", {31'd0, cbusy});
    check("post_reset_data", rdata[31:0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
